// File: rtl/grid_overlay_pkg.sv
// Shared mode encodings, default colours and bus widths for the grid overlay.
package grid_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_LINES  = 2'b01,
    MODE_DOTS   = 2'b10,
    MODE_CURSOR = 2'b11
  } grid_mode_e;

  localparam logic [7:0] DEF_LINE_COLOR   = 8'hE0;
  localparam logic [7:0] DEF_CURSOR_COLOR = 8'h1C;

  localparam int HC_W  = 11;  // hcount width
  localparam int VC_W  = 10;  // vcount width
  localparam int IDX_W = 5;   // cell column/row index width

endpackage

// File: rtl/grid_overlay_if.sv
// Timing-generator-to-mixer bus for the grid overlay: raster position and
// controls in, overlay pixel out.
interface grid_overlay_if;
  import grid_pkg::*;

  logic [HC_W-1:0]  hcount;
  logic [VC_W-1:0]  vcount;
  logic [1:0]       mode;
  logic [IDX_W-1:0] cur_col;
  logic [IDX_W-1:0] cur_row;
  logic [7:0]       pixel_grid;
  logic             grid_hit;

  modport master (output hcount, vcount, mode, cur_col, cur_row,
                  input  pixel_grid, grid_hit);
  modport slave  (input  hcount, vcount, mode, cur_col, cur_row,
                  output pixel_grid, grid_hit);
endinterface

// File: rtl/grid_axis_counter.sv
// One raster axis of the grid: tracks the phase inside the current cell and
// the cell index from an incremental counter, restarted whenever the raster
// position equals ORIGIN. The span ends after the last cell so positions
// past the grid never alias onto a line.
module grid_axis_counter #(
  parameter int ORIGIN  = 26,
  parameter int PITCH   = 26,
  parameter int N_CELLS = 29,
  parameter int POS_W   = 11,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_step_en,
  output logic             o_line,
  output logic [IDX_W-1:0] o_cell_idx,
  output logic             o_in_span
);

  localparam int PH_W = $clog2(PITCH);

  logic [PH_W-1:0]  r_ph;
  logic [IDX_W-1:0] r_idx;
  logic             r_in;

  // Phase/cell counter; ORIGIN always resynchronises, even after a jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph  <= '0;
      r_idx <= '0;
      r_in  <= 1'b0;
    end else if (i_step_en) begin
      if (i_pos == POS_W'(ORIGIN)) begin
        r_ph  <= '0;
        r_idx <= '0;
        r_in  <= 1'b1;
      end else if (r_in) begin
        if (r_ph == PH_W'(PITCH-1)) begin
          r_ph <= '0;
          if (r_idx == IDX_W'(N_CELLS)) r_in  <= 1'b0;
          else                          r_idx <= r_idx + 1'b1;
        end else begin
          r_ph <= r_ph + 1'b1;
        end
      end
    end
  end

  assign o_line     = r_in && (r_ph == '0) && (r_idx <= IDX_W'(N_CELLS));
  assign o_cell_idx = r_idx;
  assign o_in_span  = r_in;

endmodule

// File: rtl/grid_overlay.sv
// Programmable grid overlay: per-axis phase counters feed a registered pixel
// stage. Mode, cursor and blink state only change at frame start so a frame
// is always drawn consistently. Latency is 2 vclk from hcount/vcount.
module grid_overlay
  import grid_pkg::*;
#(
  parameter int         H_ORIGIN     = 26,
  parameter int         V_ORIGIN     = 17,
  parameter int         CELL_W       = 26,
  parameter int         CELL_H       = 26,
  parameter int         N_COLS       = 29,
  parameter int         N_ROWS       = 22,
  parameter logic [7:0] LINE_COLOR   = DEF_LINE_COLOR,
  parameter logic [7:0] CURSOR_COLOR = DEF_CURSOR_COLOR,
  parameter int         BLINK_FRAMES = 30
) (
  input logic           vclk,
  input logic           rst,
  grid_overlay_if.slave bus
);

  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             w_frame_start, w_line_start;
  logic             w_v_line, w_h_line, w_in_h, w_in_v;
  logic [IDX_W-1:0] w_hcol, w_vrow;
  logic             w_h_ext, w_line_any, w_dot, w_cur_fill;
  logic [7:0]       w_pix_nxt;

  grid_mode_e       r_mode_q;
  logic [IDX_W-1:0] r_cur_col_q, r_cur_row_q;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_on;
  logic [7:0]       r_pixel;
  logic             r_hit;

  assign w_frame_start = (bus.hcount == '0) && (bus.vcount == '0);
  assign w_line_start  = (bus.hcount == '0);

  grid_axis_counter #(
    .ORIGIN(H_ORIGIN), .PITCH(CELL_W), .N_CELLS(N_COLS), .POS_W(HC_W), .IDX_W(IDX_W)
  ) u_h_axis (
    .clk(vclk), .rst(rst), .i_pos(bus.hcount), .i_step_en(1'b1),
    .o_line(w_v_line), .o_cell_idx(w_hcol), .o_in_span(w_in_h)
  );

  grid_axis_counter #(
    .ORIGIN(V_ORIGIN), .PITCH(CELL_H), .N_CELLS(N_ROWS), .POS_W(VC_W), .IDX_W(IDX_W)
  ) u_v_axis (
    .clk(vclk), .rst(rst), .i_pos(bus.vcount), .i_step_en(w_line_start),
    .o_line(w_h_line), .o_cell_idx(w_vrow), .o_in_span(w_in_v)
  );

  // Frame-start sampling of controls and the blink half-period counter.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      r_mode_q    <= MODE_OFF;
      r_cur_col_q <= '0;
      r_cur_row_q <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_start) begin
      r_mode_q    <= grid_mode_e'(bus.mode);
      r_cur_col_q <= bus.cur_col;
      r_cur_row_q <= bus.cur_row;
      if (r_blink_cnt == BLK_W'(BLINK_FRAMES-1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Horizontal lines stop at the last vertical line, not at the end of the
  // last cell's span; vertical lines are drawn on every row.
  assign w_h_ext    = w_in_h && ((w_hcol < IDX_W'(N_COLS)) || w_v_line);
  assign w_line_any = w_v_line || (w_h_line && w_h_ext);
  assign w_dot      = w_v_line && w_h_line;
  assign w_cur_fill = !w_line_any && w_in_h && w_in_v && r_blink_on &&
                      (w_hcol == r_cur_col_q) && (w_vrow == r_cur_row_q) &&
                      (r_cur_col_q < IDX_W'(N_COLS)) && (r_cur_row_q < IDX_W'(N_ROWS));

  // Next overlay pixel from the current counter state and frame mode.
  always_comb begin
    w_pix_nxt = '0;
    unique case (r_mode_q)
      MODE_OFF:    w_pix_nxt = '0;
      MODE_LINES:  if (w_line_any) w_pix_nxt = LINE_COLOR;
      MODE_DOTS:   if (w_dot)      w_pix_nxt = LINE_COLOR;
      MODE_CURSOR: begin
        if (w_line_any)      w_pix_nxt = LINE_COLOR;
        else if (w_cur_fill) w_pix_nxt = CURSOR_COLOR;
      end
      default:     w_pix_nxt = '0;
    endcase
  end

  // Registered output stage.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      r_pixel <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_pixel <= w_pix_nxt;
      r_hit   <= |w_pix_nxt;
    end
  end

  assign bus.pixel_grid = r_pixel;
  assign bus.grid_hit   = r_hit;

endmodule
